// File: rtl/burst_mem_model.sv
// burst_mem_model: behavioural burst memory with independent read and write
// engines. Reads return the first beat READ_LATENCY cycles after accept and
// then one beat per cycle; writes consume one beat per cycle with byte strobes
// and finish with a one-cycle response. Beats whose word index is >= DEPTH
// read as zero and are dropped on write (response code 2'b10).
// Optional: define BURST_MEM_MODEL_STATS_EN for saturating beat counters.
module burst_mem_model #(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 33,
    parameter int DEPTH        = 4096,
    parameter int OFFSET       = 5,
    parameter int READ_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    StartRead,
    input  logic [ADDR_WIDTH-1:0]   ReadAddress,
    input  logic [7:0]              ReadBurst,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadReady,
    output logic                    EndRead,
    output logic                    ReadBusy,
    input  logic                    StartWrite,
    input  logic [ADDR_WIDTH-1:0]   WriteAddress,
    input  logic [7:0]              WriteBurst,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [DATA_WIDTH/8-1:0] WriteStrobe,
    output logic                    WriteReady,
    output logic                    WriteResp,
    output logic [1:0]              EndWrite,
    output logic                    WriteBusy,
    output logic [31:0]             StatReadBeats,
    output logic [31:0]             StatWriteBeats
);

    localparam int IW = ADDR_WIDTH - OFFSET;
    localparam int SW = DATA_WIDTH / 8;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rState_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;

    rState_t rState;
    wState_t wState;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0] rIdx;
    logic [7:0]    rLeft;
    logic [7:0]    rWait;
    logic [IW-1:0] wIdx;
    logic [7:0]    wLeft;
    logic          wErr;

    logic                  rInRange;
    logic                  wInRange;
    logic                  rEmit;
    logic                  wEn;
    logic [DATA_WIDTH-1:0] rdWord;
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^{ReadAddress[OFFSET-1:0], WriteAddress[OFFSET-1:0]};

    // Range checks, beat-emit decision and the (pre-write) read word
    always_comb begin
        rInRange = 64'(rIdx) < 64'(DEPTH);
        wInRange = 64'(wIdx) < 64'(DEPTH);
        rEmit    = ((rState == R_WAIT) && (rWait == 8'd0)) ||
                   ((rState == R_BURST) && !EndRead);
        wEn      = (wState == W_DATA) && wInRange;
        rdWord   = rInRange ? mem[rIdx[MW-1:0]] : '0;
    end

    // Memory array: byte-strobed write port, never cleared by reset
    always_ff @(posedge clk) begin
        if (wEn) begin
            for (int unsigned k = 0; k < SW; k++) begin
                if (WriteStrobe[k]) begin
                    mem[wIdx[MW-1:0]][8*k +: 8] <= WriteData[8*k +: 8];
                end
            end
        end
    end

    // Read engine: accept, latency countdown, then gap-free beats
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rState    <= R_IDLE;
            rIdx      <= '0;
            rLeft     <= '0;
            rWait     <= '0;
            ReadData  <= '0;
            ReadReady <= 1'b0;
            EndRead   <= 1'b0;
            ReadBusy  <= 1'b0;
        end else begin
            ReadReady <= 1'b0;
            EndRead   <= 1'b0;
            ReadData  <= '0;
            if (rEmit) begin
                ReadReady <= 1'b1;
                ReadData  <= rdWord;
                EndRead   <= (rLeft == 8'd0);
                rLeft     <= rLeft - 8'd1;
                rIdx      <= rIdx + IW'(1);
            end
            case (rState)
                R_IDLE: begin
                    if (StartRead) begin
                        rIdx     <= ReadAddress[ADDR_WIDTH-1:OFFSET];
                        rLeft    <= ReadBurst;
                        rWait    <= 8'(READ_LATENCY - 1);
                        ReadBusy <= 1'b1;
                        rState   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rWait == 8'd0) rState <= R_BURST;
                    else               rWait  <= rWait - 8'd1;
                end
                R_BURST: begin
                    // EndRead high means the last beat is on the bus this cycle
                    if (EndRead) begin
                        ReadBusy <= 1'b0;
                        rState   <= R_IDLE;
                    end
                end
                default: rState <= R_IDLE;
            endcase
        end
    end

    // Write engine: accept, consume beats, then one-cycle response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wState     <= W_IDLE;
            wIdx       <= '0;
            wLeft      <= '0;
            wErr       <= 1'b0;
            WriteReady <= 1'b0;
            WriteResp  <= 1'b0;
            EndWrite   <= 2'b00;
            WriteBusy  <= 1'b0;
        end else begin
            WriteResp <= 1'b0;
            EndWrite  <= 2'b00;
            case (wState)
                W_IDLE: begin
                    if (StartWrite) begin
                        wIdx       <= WriteAddress[ADDR_WIDTH-1:OFFSET];
                        wLeft      <= WriteBurst;
                        wErr       <= 1'b0;
                        WriteReady <= 1'b1;
                        WriteBusy  <= 1'b1;
                        wState     <= W_DATA;
                    end
                end
                W_DATA: begin
                    wIdx <= wIdx + IW'(1);
                    wErr <= wErr | !wInRange;
                    if (wLeft == 8'd0) begin
                        WriteReady <= 1'b0;
                        wState     <= W_RESP;
                    end else begin
                        wLeft <= wLeft - 8'd1;
                    end
                end
                W_RESP: begin
                    WriteResp <= 1'b1;
                    EndWrite  <= wErr ? 2'b10 : 2'b00;
                    WriteBusy <= 1'b0;
                    wState    <= W_IDLE;
                end
                default: wState <= W_IDLE;
            endcase
        end
    end

`ifdef BURST_MEM_MODEL_STATS_EN
    // Saturating counters of delivered read beats and consumed write beats
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            StatReadBeats  <= '0;
            StatWriteBeats <= '0;
        end else begin
            if (ReadReady && (StatReadBeats != '1))   StatReadBeats  <= StatReadBeats + 32'd1;
            if (WriteReady && (StatWriteBeats != '1)) StatWriteBeats <= StatWriteBeats + 32'd1;
        end
    end
`else
    assign StatReadBeats  = '0;
    assign StatWriteBeats = '0;
`endif

endmodule

// File: tb/tb_burst_mem_model.sv
// Scoreboard bench for burst_mem_model: expected read beats are pushed when a
// read is issued (from a byte-level memory model) and popped as beats appear.
module tb_burst_mem_model;

    localparam int DW    = 256;
    localparam int AW    = 33;
    localparam int DEPTH = 4096;
    localparam int LAT   = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            StartRead, StartWrite;
    logic [AW-1:0]   ReadAddress, WriteAddress;
    logic [7:0]      ReadBurst, WriteBurst;
    logic [DW-1:0]   ReadData, WriteData;
    logic [DW/8-1:0] WriteStrobe;
    logic            ReadReady, EndRead, ReadBusy;
    logic            WriteReady, WriteResp, WriteBusy;
    logic [1:0]      EndWrite;
    logic [31:0]     StatReadBeats, StatWriteBeats;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] expQ [$];
    logic [DW-1:0] modelMem [int unsigned];

    burst_mem_model #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .OFFSET      (5),
        .READ_LATENCY(LAT)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .StartRead     (StartRead),
        .ReadAddress   (ReadAddress),
        .ReadBurst     (ReadBurst),
        .ReadData      (ReadData),
        .ReadReady     (ReadReady),
        .EndRead       (EndRead),
        .ReadBusy      (ReadBusy),
        .StartWrite    (StartWrite),
        .WriteAddress  (WriteAddress),
        .WriteBurst    (WriteBurst),
        .WriteData     (WriteData),
        .WriteStrobe   (WriteStrobe),
        .WriteReady    (WriteReady),
        .WriteResp     (WriteResp),
        .EndWrite      (EndWrite),
        .WriteBusy     (WriteBusy),
        .StatReadBeats (StatReadBeats),
        .StatWriteBeats(StatWriteBeats)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic modelWrite(input int unsigned idx, input logic [DW-1:0] d, input logic [DW/8-1:0] strb);
        logic [DW-1:0] cur;
        cur = modelMem.exists(idx) ? modelMem[idx] : '0;
        for (int k = 0; k < DW/8; k++) begin
            if (strb[k]) cur[8*k +: 8] = d[8*k +: 8];
        end
        modelMem[idx] = cur;
    endtask

    task automatic writeBurst(input logic [AW-1:0] addr, input int n,
                              input logic [DW-1:0] d0, input logic [DW/8-1:0] strb);
        logic [27:0] idx;
        logic        err;
        idx = addr[AW-1:5];
        err = 1'b0;
        @(posedge clk); #1;
        StartWrite = 1'b1; WriteAddress = addr; WriteBurst = 8'(n - 1);
        @(posedge clk); #1;
        StartWrite = 1'b0;
        for (int i = 0; i < n; i++) begin
            WriteData = d0 + DW'(i); WriteStrobe = strb;
            @(negedge clk);
            checkVal("wready", WriteReady, 1);
            if (idx < DEPTH) modelWrite(int'(idx), d0 + DW'(i), strb);
            else             err = 1'b1;
            idx = idx + 28'd1;
            @(posedge clk); #1;
        end
        WriteStrobe = '0;
        @(negedge clk);
        checkVal("wready_off", WriteReady, 0);
        checkVal("wresp_early", WriteResp, 0);
        @(negedge clk);
        checkVal("wresp", WriteResp, 1);
        checkVal("endwrite", EndWrite, err ? 2'b10 : 2'b00);
        @(negedge clk);
        checkVal("wresp_pulse", WriteResp, 0);
        checkVal("endwrite_idle", EndWrite, 0);
    endtask

    // intrude: pulse a second StartRead at intrAddr while waiting.
    // resetAt: assert reset while beat resetAt (1-based) is on the bus; 0 = never.
    task automatic readBurst(input logic [AW-1:0] addr, input int n, input bit intrude,
                             input logic [AW-1:0] intrAddr, input int resetAt);
        logic [27:0]   idx;
        logic [DW-1:0] exp;
        int            acc;
        int            guard;
        idx = addr[AW-1:5];
        for (int i = 0; i < n; i++) begin
            if (idx >= DEPTH)               expQ.push_back('0);
            else if (modelMem.exists(int'(idx))) expQ.push_back(modelMem[int'(idx)]);
            else                            expQ.push_back('0);
            idx = idx + 28'd1;
        end
        @(posedge clk); #1;
        StartRead = 1'b1; ReadAddress = addr; ReadBurst = 8'(n - 1);
        @(posedge clk); #1;
        acc = cyc;
        StartRead = 1'b0;
        if (intrude) begin
            @(posedge clk); #1;
            StartRead = 1'b1; ReadAddress = intrAddr; ReadBurst = 8'd0;
            @(posedge clk); #1;
            StartRead = 1'b0;
        end
        @(negedge clk);
        checkVal("rbusy", ReadBusy, 1);
        guard = 0;
        while (!ReadReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ReadReady) begin
            checkVal("rtimeout", 0, 1);
            expQ.delete();
            return;
        end
        checkVal("rlatency", DW'(cyc - acc), DW'(LAT));
        for (int b = 0; b < n; b++) begin
            if (b > 0) @(negedge clk);
            checkVal("rvalid", ReadReady, 1);
            exp = expQ.pop_front();
            checkVal("rdata", ReadData, exp);
            checkVal("endread", EndRead, (b == n - 1) ? 1 : 0);
            if (resetAt == b + 1) begin
                resetn = 1'b0;
                @(posedge clk); #1;
                checkVal("rst_rready", ReadReady, 0);
                checkVal("rst_rbusy", ReadBusy, 0);
                checkVal("rst_endread", EndRead, 0);
                expQ.delete();
                repeat (2) @(posedge clk);
                #1 resetn = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    checkVal("post_rst_quiet", {ReadReady, EndRead}, 0);
                end
                return;
            end
        end
        @(negedge clk);
        checkVal("rready_off", ReadReady, 0);
        checkVal("endread_off", EndRead, 0);
        checkVal("rbusy_off", ReadBusy, 0);
        repeat (3) begin
            @(negedge clk);
            checkVal("no_extra_beat", ReadReady, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        StartRead = 1'b0; StartWrite = 1'b0;
        ReadAddress = '0; WriteAddress = '0; ReadBurst = '0; WriteBurst = '0;
        WriteData = '0; WriteStrobe = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_outputs", {ReadReady, EndRead, ReadBusy, WriteReady, WriteResp, EndWrite, WriteBusy}, 0);
        checkVal("rst_rdata", ReadData, 0);
        checkVal("rst_stats", {StatReadBeats, StatWriteBeats}, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // 4-beat write then read-back at 0x0
        writeBurst(33'h0, 4, 256'd1, '1);
        readBurst(33'h0, 4, 1'b0, '0, 0);
`ifdef BURST_MEM_MODEL_STATS_EN
        checkVal("stat_read", StatReadBeats, 4);
        checkVal("stat_write", StatWriteBeats, 4);
`else
        checkVal("stat_read", StatReadBeats, 0);
        checkVal("stat_write", StatWriteBeats, 0);
`endif

        // partial strobe over a zeroed word at 0x20
        writeBurst(33'h20, 1, '0, '1);
        writeBurst(33'h20, 1, '1, 32'h0000_000F);
        readBurst(33'h20, 1, 1'b0, '0, 0);

        // last in-range word: second beat dropped, error response
        writeBurst(33'((DEPTH - 1) * 32), 2, 256'hA5A5_0001, '1);
        readBurst(33'((DEPTH - 1) * 32), 2, 1'b0, '0, 0);

        // second StartRead during the latency wait is ignored
        readBurst(33'h0, 4, 1'b1, 33'h0000_2000, 0);

        // reset during beat 2 of an 8-beat read, then memory intact
        writeBurst(33'h0, 8, 256'h100, '1);
        readBurst(33'h0, 8, 1'b0, '0, 2);
        readBurst(33'h0, 8, 1'b0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_mem_model.md
BURST_MEM_MODEL -- requirements
Module: burst_mem_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: data beat width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 33: byte address width.
REQ-003 SHALL have parameter DEPTH, default 4096: number of DATA_WIDTH words stored.
REQ-004 SHALL have parameter OFFSET, default 5: byte-to-word shift; word index = address >> OFFSET.
REQ-005 SHALL have parameter READ_LATENCY, default 4: cycles from read accept to first beat, legal range 1..255.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports StartRead in 1, ReadAddress in ADDR_WIDTH, and ReadBurst in 8: read request, with beats = ReadBurst+1.
REQ-009 SHALL have ports ReadData out DATA_WIDTH, ReadReady out 1, EndRead out 1, and ReadBusy out 1.
REQ-010 SHALL have ports StartWrite in 1, WriteAddress in ADDR_WIDTH, WriteBurst in 8, WriteData in DATA_WIDTH, and WriteStrobe in DATA_WIDTH/8.
REQ-011 SHALL have ports WriteReady out 1, WriteResp out 1, EndWrite out 2 (response code), and WriteBusy out 1.
REQ-012 SHALL have ports StatReadBeats out 32 and StatWriteBeats out 32.

Function
REQ-013 SHALL run the read FSM through states R_IDLE, R_WAIT, R_BURST, returning to R_IDLE after the last beat.
- StartRead is accepted only in R_IDLE.
- Accept latches the word index and beat count, then enters R_WAIT; ReadBusy=1 outside R_IDLE.
REQ-014 SHALL assert ReadReady with the first beat exactly READ_LATENCY cycles after the accept edge, then one beat per consecutive cycle, with no gaps.
REQ-015 SHALL increment the word index by 1 per beat, wrapping modulo 2^(ADDR_WIDTH-OFFSET), and return 0 for any beat whose index >= DEPTH.
REQ-016 SHALL pulse EndRead for one cycle, coincident with the last ReadReady beat.
REQ-017 SHALL ignore StartRead while ReadBusy=1: no latch and no side effect.
REQ-018 SHALL run the write FSM through states W_IDLE, W_DATA, W_RESP.
- StartWrite in W_IDLE latches the index and count and enters W_DATA.
- WriteReady=1 throughout W_DATA; one beat is consumed on each cycle with WriteReady=1.
REQ-019 SHALL update byte k of the target word only when WriteStrobe[k]=1; beats with index >= DEPTH are dropped.
REQ-020 SHALL deassert WriteReady after the last beat and enter W_RESP, then one cycle later pulse WriteResp for one cycle and return to W_IDLE.
REQ-021 SHALL drive EndWrite=2'b00 with WriteResp if every beat was in range, otherwise 2'b10; EndWrite is 2'b00 when WriteResp=0.
REQ-022 SHALL ignore StartWrite while WriteBusy=1.
REQ-023 SHALL run the read and write engines independently.
- If a read beat and a write beat hit the same word in the same cycle, the read returns the pre-write value.
REQ-024 SHALL support StartRead and StartWrite accepted in the same cycle.

Reset
REQ-025 SHALL, while resetn=0, force all outputs to 0 and both FSMs to their IDLE states, with counters cleared.
REQ-026 SHALL abort an in-flight burst on reset with no EndRead or WriteResp, and SHALL leave memory contents unchanged by reset.

Configuration
REQ-027 SHALL, with macro BURST_MEM_MODEL_STATS_EN defined, count accepted ReadReady beats in StatReadBeats and consumed write beats in StatWriteBeats; both saturate at 2^32-1.
REQ-028 SHALL, without BURST_MEM_MODEL_STATS_EN, tie StatReadBeats and StatWriteBeats to 0 and synthesise no counter logic.

Verification
REQ-029 SHALL cover: write 4 beats at 0x0 with strobe all-ones and data 1..4, then read 4 beats at 0x0 -> ReadData 1,2,3,4; first beat 4 cycles after accept; EndRead on beat 4; EndWrite=00.
REQ-030 SHALL cover: write 1 beat at 0x20 with strobe 0x0000000F, data all-FF, over word=0 -> reading 0x20 returns 0x...FFFFFFFF in low 4 bytes, upper bytes 0.
REQ-031 SHALL cover: write 2 beats at word DEPTH-1 -> first beat stored, second dropped, WriteResp with EndWrite=2'b10; reading word DEPTH-1 returns the first beat.
REQ-032 SHALL cover: StartRead pulsed again during R_WAIT with a different address -> ignored; only the original burst is returned.
REQ-033 SHALL cover: resetn low during beat 2 of an 8-beat read -> ReadReady and ReadBusy are 0 next edge, no EndRead; a subsequent read returns the stored data intact.
REQ-034 SHALL cover: with BURST_MEM_MODEL_STATS_EN, the REQ-029 sequence -> StatReadBeats=4, StatWriteBeats=4; without the macro both stay 0.
